// File: rtl/mem_sp_ctrl_pkg.sv
// Shared definitions for the single-port memory controller.
//   state_t : controller FSM states (idle service / clear sweep)
//   nbytes  : number of byte lanes in a data word
package mem_sp_ctrl_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // Replaces the old NBYTES macro; DWIDTH is expected to be a multiple of 8.
   function automatic int unsigned nbytes(input int unsigned dwidth);
      return dwidth / 8;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x DWIDTH storage, per-byte write enable, registered read.
//   clk    : clock
//   rst_n  : async active-low reset, clears only the read register
//   we     : write strobe
//   re     : read strobe; latches mem[addr] into rdata
//   addr   : shared word address
//   wdata  : write data
//   be     : byte enables for writes
//   rdata  : registered read data, held between reads
module mem_array
   import mem_sp_ctrl_pkg::*;
#(
   parameter int unsigned AWIDTH = 5,
   parameter int unsigned DWIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        we,
   input  logic                        re,
   input  logic [AWIDTH-1:0]           addr,
   input  logic [DWIDTH-1:0]           wdata,
   input  logic [nbytes(DWIDTH)-1:0]   be,
   output logic [DWIDTH-1:0]           rdata
);

   localparam int unsigned DEPTH  = 2 ** AWIDTH;
   localparam int unsigned NBYTES = nbytes(DWIDTH);

   logic [DWIDTH-1:0] mem [DEPTH];

   // Storage is deliberately not reset; the controller's clear sweep initialises it.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_sp_ctrl.sv
// Single-port synchronous RAM controller with req/ack handshake, byte
// enables, registered read path and a hardware clear engine.
//   clk    : clock
//   rst_n  : async active-low reset; starts a full clear sweep on release
//   req    : access request, held until ack
//   wr     : 1 = write, 0 = read (qualified by req)
//   addr   : word address
//   wdata  : write data
//   be     : byte enables for writes
//   clr    : pulse, starts a clear sweep when idle
//   ack    : request accepted this cycle (combinational)
//   rdata  : registered read data, held until next acked read
//   rvalid : one-cycle pulse after an acked read
//   busy   : clear sweep in progress
module mem_sp_ctrl
   import mem_sp_ctrl_pkg::*;
#(
   parameter int unsigned        AWIDTH  = 5,
   parameter int unsigned        DWIDTH  = 16,
   parameter logic [DWIDTH-1:0]  CLR_VAL = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req,
   input  logic                        wr,
   input  logic [AWIDTH-1:0]           addr,
   input  logic [DWIDTH-1:0]           wdata,
   input  logic [nbytes(DWIDTH)-1:0]   be,
   input  logic                        clr,
   output logic                        ack,
   output logic [DWIDTH-1:0]           rdata,
   output logic                        rvalid,
   output logic                        busy
);

   localparam int unsigned       NBYTES   = nbytes(DWIDTH);
   localparam logic [AWIDTH-1:0] LAST_ADR = '1;

   state_t            state, state_nx;
   logic [AWIDTH-1:0] clr_cnt, clr_cnt_nx;

   logic                arr_we;
   logic                arr_re;
   logic [AWIDTH-1:0]   arr_addr;
   logic [DWIDTH-1:0]   arr_wdata;
   logic [NBYTES-1:0]   arr_be;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nx;
         clr_cnt <= clr_cnt_nx;
      end
   end

   // Counter saturates at the last word; leaving CLEAR is what ends the sweep.
   always_comb begin
      state_nx   = state;
      clr_cnt_nx = clr_cnt;
      case (state)
         ST_CLEAR: begin
            if (clr_cnt == LAST_ADR) begin
               state_nx = ST_IDLE;
            end else begin
               clr_cnt_nx = clr_cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            if (clr) begin
               state_nx   = ST_CLEAR;
               clr_cnt_nx = '0;
            end
         end
         default: begin
            state_nx   = ST_CLEAR;
            clr_cnt_nx = '0;
         end
      endcase
   end

   assign busy = (state == ST_CLEAR);
   // clr beats a simultaneous request; the master simply keeps req high.
   assign ack  = req & ~busy & ~clr;

   // The sweep owns the array port while busy; the master cannot reach it then.
   always_comb begin
      arr_we    = 1'b0;
      arr_re    = 1'b0;
      arr_addr  = addr;
      arr_wdata = wdata;
      arr_be    = be;
      if (busy) begin
         arr_we    = 1'b1;
         arr_addr  = clr_cnt;
         arr_wdata = CLR_VAL;
         arr_be    = '1;
      end else begin
         arr_we = ack & wr;
         arr_re = ack & ~wr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid <= 1'b0;
      end else begin
         rvalid <= ack & ~wr;
      end
   end

   mem_array #(
      .AWIDTH (AWIDTH),
      .DWIDTH (DWIDTH)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (arr_we),
      .re    (arr_re),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .be    (arr_be),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_mem_sp_ctrl.sv
module tb_mem_sp_ctrl;

   localparam int          AW    = 5;
   localparam int          DW    = 16;
   localparam int          NB    = 2;
   localparam int          DEPTH = 32;
   localparam logic [15:0] CLR   = 16'h0000;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          req   = 1'b0;
   logic          wr    = 1'b0;
   logic          clr   = 1'b0;
   logic [AW-1:0] addr  = '0;
   logic [DW-1:0] wdata = '0;
   logic [NB-1:0] be    = '0;
   logic          ack, rvalid, busy;
   logic [DW-1:0] rdata;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model and scoreboard
   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_hold = '0;
   bit            rv_pend  = 1'b0;
   bit            mon_on   = 1'b0;
   int            m_busy   = DEPTH;
   bit            exp_ack, got_ack, got_busy;

   mem_sp_ctrl #(
      .AWIDTH  (AW),
      .DWIDTH  (DW),
      .CLR_VAL (CLR)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .wr     (wr),
      .addr   (addr),
      .wdata  (wdata),
      .be     (be),
      .clr    (clr),
      .ack    (ack),
      .rdata  (rdata),
      .rvalid (rvalid),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   // Called at a negedge; drives one cycle, updates the model at the posedge,
   // returns at the following negedge.
   task automatic drive_cycle(input bit r, input bit w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [NB-1:0] b, input bit c);
      req = r; wr = w; addr = a; wdata = d; be = b; clr = c;
      #1;
      exp_ack  = r && (m_busy == 0) && !c;
      got_ack  = ack;
      got_busy = busy;
      @(posedge clk);
      if (exp_ack) begin
         if (w) begin
            for (int i = 0; i < NB; i++)
               if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
         end else begin
            exp_q.push_back(model[a]);
            rv_pend = 1'b1;
         end
      end
      if (m_busy > 0) m_busy--;
      else if (c) begin
         m_busy = DEPTH;
         foreach (model[k]) model[k] = CLR;
      end
      @(negedge clk);
      req = 1'b0; wr = 1'b0; clr = 1'b0; be = '0;
   endtask

   task automatic assert_reset();
      rst_n  = 1'b0;
      mon_on = 1'b0;
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n    = 1'b1;
      m_busy   = DEPTH;
      foreach (model[k]) model[k] = CLR;
      exp_q.delete();
      exp_hold = '0;
      rv_pend  = 1'b0;
      mon_on   = 1'b1;
   endtask

   // Scoreboard monitor: rvalid must match acked reads, rdata must match the
   // last popped expectation every cycle (it holds between reads).
   always @(posedge clk) begin
      #1;
      if (mon_on) begin
         n_checks++;
         if (rvalid !== rv_pend) begin
            n_fail++;
            $display("FAIL rvalid: got %b expected %b at %0t", rvalid, rv_pend, $time);
         end
         if (rv_pend) begin
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL scoreboard: got read with no expectation at %0t", $time);
            end else begin
               exp_hold = exp_q.pop_front();
            end
         end
         n_checks++;
         if (rdata !== exp_hold) begin
            n_fail++;
            $display("FAIL rdata: got %h expected %h at %0t", rdata, exp_hold, $time);
         end
      end
      rv_pend = 1'b0;
   end

   task automatic test_reset();
      int n;
      @(negedge clk);
      assert_reset();
      req = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b expected 1", busy); end
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b expected 0", ack); end
      n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b expected 0", rvalid); end
      n_checks++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0000", rdata); end
      req = 1'b0;
      release_reset();
      n = 0;
      for (int i = 0; i < 40; i++) begin
         drive_cycle(0, 0, '0, '0, '0, 0);
         if (!got_busy) break;
         n++;
      end
      n_checks++; if (n != DEPTH) begin n_fail++; $display("FAIL rst_sweep_len: got %0d expected %0d", n, DEPTH); end
      drive_cycle(1, 0, 5'd5, '0, '0, 0);
      n_checks++; if (got_ack !== 1'b1) begin n_fail++; $display("FAIL rd5_ack: got %b expected 1", got_ack); end
      n_checks++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL rd5_data: got %h expected 0000", rdata); end
      drive_cycle(0, 0, '0, '0, '0, 0);
   endtask

   task automatic test_write_read();
      drive_cycle(1, 1, 5'd31, 16'hA5C3, 2'b11, 0);
      n_checks++; if (got_ack !== 1'b1) begin n_fail++; $display("FAIL w31_ack: got %b expected 1", got_ack); end
      drive_cycle(1, 0, 5'd31, '0, '0, 0);
      n_checks++; if (got_ack !== 1'b1) begin n_fail++; $display("FAIL r31_ack: got %b expected 1", got_ack); end
      n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL r31_rvalid: got %b expected 1", rvalid); end
      n_checks++; if (rdata !== 16'hA5C3) begin n_fail++; $display("FAIL r31_data: got %h expected a5c3", rdata); end
      drive_cycle(0, 0, '0, '0, '0, 0);
   endtask

   task automatic test_byte_enables();
      logic [DW-1:0] d [3];
      logic [NB-1:0] b [3];
      d[0] = 16'h1234; b[0] = 2'b11;
      d[1] = 16'hFFFF; b[1] = 2'b01;
      d[2] = 16'h0000; b[2] = 2'b00;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1, 1, 5'd3, d[i], b[i], 0);
         n_checks++; if (got_ack !== 1'b1) begin n_fail++; $display("FAIL be_w%0d_ack: got %b expected 1", i, got_ack); end
      end
      drive_cycle(1, 0, 5'd3, '0, '0, 0);
      n_checks++; if (rdata !== 16'h12FF) begin n_fail++; $display("FAIL be_data: got %h expected 12ff", rdata); end
      drive_cycle(0, 0, '0, '0, '0, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 31; i++) begin
         drive_cycle(1, 1, 5'(31 - i), 16'(i), 2'b11, 0);
         n_checks++; if (got_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_w%0d_ack: got %b expected 1", i, got_ack); end
      end
      for (int i = 0; i < 31; i++) begin
         drive_cycle(1, 0, 5'(31 - i), '0, '0, 0);
         n_checks++; if (got_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_r%0d_ack: got %b expected 1", i, got_ack); end
      end
      n_checks++; if (rdata !== 16'd30) begin n_fail++; $display("FAIL b2b_last: got %h expected 001e", rdata); end
      drive_cycle(0, 0, '0, '0, '0, 0);
   endtask

   task automatic test_clr_priority();
      int n;
      drive_cycle(1, 1, 5'd2, 16'hBEEF, 2'b11, 0);
      drive_cycle(1, 0, 5'd2, '0, '0, 1);
      n_checks++; if (got_ack !== 1'b0) begin n_fail++; $display("FAIL clrreq_ack: got %b expected 0", got_ack); end
      n = 0;
      for (int i = 0; i < 40; i++) begin
         drive_cycle(1, 0, 5'd2, '0, '0, 0);
         if (got_ack) break;
         n++;
      end
      n_checks++; if (n != DEPTH) begin n_fail++; $display("FAIL clrreq_wait: got %0d expected %0d", n, DEPTH); end
      n_checks++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL clrreq_data: got %h expected 0000", rdata); end
      drive_cycle(0, 0, '0, '0, '0, 0);
   endtask

   task automatic test_reset_abort();
      int n;
      drive_cycle(1, 1, 5'd7, 16'h1357, 2'b11, 0);
      drive_cycle(1, 0, 5'd7, '0, '0, 0);
      drive_cycle(0, 0, '0, '0, '0, 1);
      for (int i = 0; i < 10; i++) drive_cycle(0, 0, '0, '0, '0, 0);
      n_checks++; if (rdata !== 16'h1357) begin n_fail++; $display("FAIL abort_hold: got %h expected 1357", rdata); end
      assert_reset();
      n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL abort_rvalid: got %b expected 0", rvalid); end
      n_checks++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL abort_rdata: got %h expected 0000", rdata); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy: got %b expected 1", busy); end
      release_reset();
      n = 0;
      for (int i = 0; i < 40; i++) begin
         drive_cycle(0, 0, '0, '0, '0, (i == 3) || (i == 20));
         if (!got_busy) break;
         n++;
      end
      n_checks++; if (n != DEPTH) begin n_fail++; $display("FAIL abort_sweep_len: got %0d expected %0d", n, DEPTH); end
      drive_cycle(1, 0, 5'd7, '0, '0, 0);
      n_checks++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL abort_rd7: got %h expected 0000", rdata); end
      drive_cycle(0, 0, '0, '0, '0, 0);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_enables();
      test_back_to_back();
      test_clr_priority();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
